rom_load_scheduler: RTL and testbench

//  Sits between the per-game ROM loader and memory during MRA download.

---
 rtl/rom_load_scheduler_if.sv | 10 +
 rtl/rom_load_scheduler.sv | 150 +++++++++++++++
 tb/tb_rom_load_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_load_scheduler_if.sv
// rtl/rom_load_scheduler_if.sv - shared SDRAM write port between the ROM load scheduler and memory
interface rom_load_scheduler_if;
    logic        sdram_req;
    logic [25:0] sdram_addr;
    logic [15:0] sdram_din;
    logic        sdram_ack;

    modport master (output sdram_req, output sdram_addr, output sdram_din, input sdram_ack);
    modport slave  (input sdram_req, input sdram_addr, input sdram_din, output sdram_ack);
endinterface

// File: rtl/rom_load_scheduler.sv
// rtl/rom_load_scheduler.sv - relocates region-tagged ROM words, buffers SDRAM writes, passes PROM words to BRAM
module rom_load_scheduler #(
    parameter int           FIFO_DEPTH  = 4,
    parameter logic [233:0] REGION_BASE = 234'h0,
    parameter logic [8:0]   SDRAM_MASK  = 9'b001111111
) (
    input  logic                   clk_sys,
    input  logic                   nreset,
    input  logic                   load_en,
    input  logic [8:0]             region_we,
    input  logic [25:0]            rom_addr,
    input  logic [15:0]            rom_data,
    output logic                   ioctl_wait,
    rom_load_scheduler_if.master   sdram,
    output logic [8:0]             bram_we,
    output logic [25:0]            bram_addr,
    output logic [15:0]            bram_data,
    output logic                   load_done,
    output logic                   multi_err
);
    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_CNT = CW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK} state_t;

    state_t        state, state_next;
    logic [41:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, pop, issue_load;
    logic          sel_valid, sel_sdram, multi_hit;
    logic [25:0]   sel_base, reloc_addr;
    logic [8:0]    sel_onehot;
    logic          load_en_d, seen_load;

    // Descending scan so the lowest set strobe is the one that survives.
    always_comb begin
        sel_valid  = 1'b0;
        sel_sdram  = 1'b0;
        sel_base   = '0;
        sel_onehot = '0;
        for (int i = 8; i >= 0; i--) begin
            if (region_we[i]) begin
                sel_valid  = 1'b1;
                sel_sdram  = SDRAM_MASK[i];
                sel_base   = REGION_BASE[26*i +: 26];
                sel_onehot = 9'(1) << i;
            end
        end
    end

    assign multi_hit  = |(region_we & (region_we - 9'd1));
    assign reloc_addr = sel_base + rom_addr;
    assign push       = load_en && sel_valid && sel_sdram && (count != FULL_CNT);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {reloc_addr, rom_data};
    end

    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count      <= count_next;
            ioctl_wait <= (count_next >= WAIT_CNT);
        end
    end

    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (count != '0) state_next = S_ISSUE;
            S_ISSUE:    state_next = S_WAIT_ACK;
            S_WAIT_ACK: if (sdram.sdram_ack) state_next = (count_next != '0) ? S_ISSUE : S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        issue_load = (state == S_ISSUE);
        pop        = (state == S_WAIT_ACK) && sdram.sdram_ack;
    end

    // Request, address and data are captured once at ISSUE and held until the ack.
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            sdram.sdram_req  <= 1'b0;
            sdram.sdram_addr <= '0;
            sdram.sdram_din  <= '0;
        end else if (issue_load) begin
            sdram.sdram_req  <= 1'b1;
            sdram.sdram_addr <= mem[rd_ptr][41:16];
            sdram.sdram_din  <= mem[rd_ptr][15:0];
        end else if (pop) begin
            sdram.sdram_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            bram_we   <= '0;
            bram_addr <= '0;
            bram_data <= '0;
        end else if (load_en && sel_valid && !sel_sdram) begin
            bram_we   <= sel_onehot;
            bram_addr <= rom_addr;
            bram_data <= rom_data;
        end else begin
            bram_we   <= '0;
        end
    end

    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            load_en_d <= 1'b0;
            seen_load <= 1'b0;
            load_done <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            load_en_d <= load_en;
            if (load_en) seen_load <= 1'b1;
            if (load_en && !load_en_d)
                load_done <= 1'b0;
            else if (!load_en && seen_load && (count == '0) && (state == S_IDLE))
                load_done <= 1'b1;
            if (load_en && multi_hit) multi_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rom_load_scheduler.sv
// tb/tb_rom_load_scheduler.sv - scoreboard bench for rom_load_scheduler
module tb_rom_load_scheduler;
    localparam logic [233:0] BASES = {{5{26'h0}}, 26'h3FFFFF0, 26'h0200000, 26'h0100000, 26'h0000000};

    logic        clk_sys = 1'b0;
    logic        nreset;
    logic        load_en;
    logic [8:0]  region_we;
    logic [25:0] rom_addr;
    logic [15:0] rom_data;
    logic        ioctl_wait;
    logic [8:0]  bram_we;
    logic [25:0] bram_addr;
    logic [15:0] bram_data;
    logic        load_done;
    logic        multi_err;
    logic        ack;

    int          checks = 0;
    int          errors = 0;
    logic [41:0] sb [$];
    logic [25:0] tb_base [9];

    always #5 clk_sys = ~clk_sys;

    rom_load_scheduler_if sif ();
    assign sif.sdram_ack = ack;

    rom_load_scheduler #(.FIFO_DEPTH(4), .REGION_BASE(BASES), .SDRAM_MASK(9'b001111111)) dut (
        .clk_sys(clk_sys), .nreset(nreset), .load_en(load_en), .region_we(region_we),
        .rom_addr(rom_addr), .rom_data(rom_data), .ioctl_wait(ioctl_wait), .sdram(sif.master),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_data(bram_data),
        .load_done(load_done), .multi_err(multi_err)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [8:0] we, input logic [25:0] a, input logic [15:0] d);
        region_we = we;
        rom_addr  = a;
        rom_data  = d;
        tick();
        region_we = '0;
    endtask

    task automatic expect_word(input int idx, input logic [25:0] a, input logic [15:0] d);
        logic [25:0] abs_addr;
        abs_addr = tb_base[idx] + a;
        sb.push_back({abs_addr, d});
    endtask

    task automatic serve(input string name);
        int n;
        logic [41:0] exp;
        n = 0;
        while (!sif.sdram_req && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sif.sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout actual=%b expected=1", name, sif.sdram_req);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_req actual=%h_%h expected=none", name, sif.sdram_addr, sif.sdram_din);
        end else begin
            exp = sb.pop_front();
            if ({sif.sdram_addr, sif.sdram_din} !== exp)
                begin errors++; $display("FAIL %s word actual=%h_%h expected=%h_%h", name, sif.sdram_addr, sif.sdram_din, exp[41:16], exp[15:0]); end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (sif.sdram_req !== 1'b0) begin errors++; $display("FAIL %s req_drop actual=%b expected=0", name, sif.sdram_req); end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (sif.sdram_req !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL %s stray_req actual=1 expected=0", name); end
    endtask

    task automatic test_reset();
        nreset = 1'b0; load_en = 1'b0; region_we = '0; rom_addr = '0; rom_data = '0; ack = 1'b0;
        tick(); tick();
        checks++;
        if ({sif.sdram_req, sif.sdram_addr, sif.sdram_din, ioctl_wait, bram_we, bram_addr, bram_data, load_done, multi_err} !== '0)
            begin errors++; $display("FAIL reset outputs actual=%b_%h_%h_%b_%h_%b_%b expected=all_zero", sif.sdram_req, sif.sdram_addr, sif.sdram_din, ioctl_wait, bram_we, load_done, multi_err); end
        nreset = 1'b1;
        tick();
        load_en = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        expect_word(0, 26'h10, 16'hBEEF);
        strobe(9'h001, 26'h10, 16'hBEEF);
        checks++;
        if (sif.sdram_req !== 1'b0) begin errors++; $display("FAIL t1_req_early actual=%b expected=0", sif.sdram_req); end
        tick();
        checks++;
        if (sif.sdram_req !== 1'b0) begin errors++; $display("FAIL t1_req_cycle1 actual=%b expected=0", sif.sdram_req); end
        tick();
        checks++;
        if (sif.sdram_req !== 1'b1) begin errors++; $display("FAIL t1_req_cycle2 actual=%b expected=1", sif.sdram_req); end
        serve("t1_word");
        expect_quiet("t1_empty", 4);
    endtask

    task automatic test_relocation();
        expect_word(3, 26'h20, 16'h1234);
        strobe(9'h008, 26'h20, 16'h1234);
        tick(); tick();
        checks++;
        if (sif.sdram_addr !== 26'h0000010) begin errors++; $display("FAIL t2_wrap actual=%h expected=0000010", sif.sdram_addr); end
        serve("t2_word");
        expect_word(1, 26'h3, 16'h5A5A);
        strobe(9'h002, 26'h3, 16'h5A5A);
        serve("t2_z80");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            expect_word(2, 26'(i + 8), 16'hC000 + 16'(i));
            strobe(9'h004, 26'(i + 8), 16'hC000 + 16'(i));
            checks++;
            if (ioctl_wait !== (i >= 2)) begin errors++; $display("FAIL t3_wait_push%0d actual=%b expected=%b", i, ioctl_wait, (i >= 2)); end
        end
        strobe(9'h004, 26'h77, 16'hDEAD);
        serve("t3_word0");
        checks++;
        if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL t3_wait_after1 actual=%b expected=1", ioctl_wait); end
        serve("t3_word1");
        checks++;
        if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL t3_wait_after2 actual=%b expected=0", ioctl_wait); end
        serve("t3_word2");
        serve("t3_word3");
        expect_quiet("t3_drop", 6);
    endtask

    task automatic test_bram_path();
        strobe(9'h080, 26'h5, 16'h00A5);
        checks++;
        if ({bram_we, bram_addr, bram_data} !== {9'h080, 26'h5, 16'h00A5})
            begin errors++; $display("FAIL t4_bram actual=%h_%h_%h expected=080_0000005_00a5", bram_we, bram_addr, bram_data); end
        tick();
        checks++;
        if (bram_we !== 9'h000) begin errors++; $display("FAIL t4_pulse actual=%h expected=000", bram_we); end
        expect_quiet("t4_no_sdram", 4);
    endtask

    task automatic test_done_abort();
        int n;
        expect_word(0, 26'h40, 16'h1111);
        strobe(9'h001, 26'h40, 16'h1111);
        expect_word(0, 26'h41, 16'h2222);
        strobe(9'h001, 26'h41, 16'h2222);
        load_en = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (load_done !== 1'b0) begin errors++; $display("FAIL t5_done_pending2 actual=%b expected=0", load_done); end
        serve("t5_word0");
        checks++;
        if (load_done !== 1'b0) begin errors++; $display("FAIL t5_done_pending1 actual=%b expected=0", load_done); end
        serve("t5_word1");
        n = 0;
        while (load_done !== 1'b1 && n < 5) begin tick(); n++; end
        checks++;
        if (load_done !== 1'b1) begin errors++; $display("FAIL t5_done_set actual=%b expected=1", load_done); end
        load_en = 1'b1;
        tick();
        checks++;
        if (load_done !== 1'b0) begin errors++; $display("FAIL t5_done_clear actual=%b expected=0", load_done); end
        strobe(9'h001, 26'h50, 16'h3333);
        n = 0;
        while (!sif.sdram_req && n < 10) begin tick(); n++; end
        nreset = 1'b0;
        #1;
        checks++;
        if ({sif.sdram_req, ioctl_wait} !== 2'b00) begin errors++; $display("FAIL t5_abort actual=%b%b expected=00", sif.sdram_req, ioctl_wait); end
        tick();
        nreset = 1'b1;
        expect_quiet("t5_flushed", 6);
    endtask

    task automatic test_conflict();
        load_en = 1'b0;
        strobe(9'h080, 26'h9, 16'h0099);
        checks++;
        if (bram_we !== 9'h000) begin errors++; $display("FAIL t6_ignored_bram actual=%h expected=000", bram_we); end
        strobe(9'h001, 26'h9, 16'h0099);
        expect_quiet("t6_ignored_sdram", 4);
        load_en = 1'b1;
        tick();
        expect_word(0, 26'h60, 16'h6060);
        strobe(9'h005, 26'h60, 16'h6060);
        checks++;
        if (multi_err !== 1'b1) begin errors++; $display("FAIL t6_multi_err actual=%b expected=1", multi_err); end
        serve("t6_word");
        expect_quiet("t6_single", 6);
        checks++;
        if (multi_err !== 1'b1) begin errors++; $display("FAIL t6_sticky actual=%b expected=1", multi_err); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left actual=%0d expected=0", sb.size()); end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) tb_base[i] = 26'h0;
        tb_base[1] = 26'h0100000;
        tb_base[2] = 26'h0200000;
        tb_base[3] = 26'h3FFFFF0;
        test_reset();
        test_single_word();
        test_relocation();
        test_backpressure();
        test_bram_path();
        test_done_abort();
        test_conflict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
